alu_dest_writeback: RTL and testbench
=====================================

Name: alu_dest_writeback

Overview:
- Return path of the ALU datapath in the multi-cycle XMakina core. Captures one ALU result plus its destination tag and routes it to one destination: register file, memory write port, PSW or PC.
- Register, PSW and PC writes complete in one cycle. Memory writes run a req/ack handshake.
- Signals completion to the control unit so the next micro-step can start.

Parameters:
- WORD_SIZE, 16, datapath width; must be even (byte lanes).
- REG_ADDR_W, 3, register-file address width (R0-R7).
- MEM_TIMEOUT, 15, cycles to wait for mem_ack before abort; used only with WB_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- res_valid  in  1  ALU result and tag are valid
- res_ready  out  1  block can accept a result
- res_data  in  WORD_SIZE  ALU result
- dest_sel  in  2  destination tag (alu_wb_pkg::dest_t)
- dest_reg  in  REG_ADDR_W  target register for DEST_REG
- byte_op  in  1  byte operation: low byte only
- rf_we  out  1  register-file write strobe
- rf_waddr  out  REG_ADDR_W  register-file write address
- rf_wdata  out  WORD_SIZE  register-file write data
- rf_wbyte_en  out  2  register-file lane enables {hi,lo}
- psw_we  out  1  PSW write strobe
- pc_we  out  1  PC write strobe
- wb_data  out  WORD_SIZE  shared write data for PSW/PC
- mem_req  out  1  memory write request
- mem_wdata  out  WORD_SIZE  memory write data
- mem_wbyte_en  out  2  memory lane enables
- mem_ack  in  1  memory write accepted
- wb_done  out  1  one-cycle pulse when writeback completes
- wb_err  out  1  one-cycle pulse on memory timeout abort

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, res_ready=1. All strobes, mem_req, wb_done and wb_err are 0. Data, address and enable registers are 0.
- FSM states: IDLE, WRITE, MEM_WAIT.
- IDLE:
  - res_ready=1.
  - On res_valid, capture res_data, dest_sel, dest_reg and byte_op.
  - DEST_MEM goes to MEM_WAIT; every other tag goes to WRITE.
- WRITE (exactly 1 cycle):
  - res_ready=0.
  - Exactly one of rf_we, psw_we or pc_we is high, selected by the captured tag.
  - wb_done=1 in the same cycle, then return to IDLE.
  - Latency is 1 cycle from acceptance to strobe. Back-to-back throughput is one result per 2 cycles.
- MEM_WAIT:
  - mem_req=1; mem_wdata and mem_wbyte_en are held stable until the cycle mem_ack is sampled high.
  - On mem_ack, wb_done pulses that cycle, mem_req drops next cycle and the FSM returns to IDLE.
  - An ack arriving in the first MEM_WAIT cycle is legal (1-cycle handshake).
  - mem_ack while not in MEM_WAIT is ignored.
- Byte rule:
  - byte_op=1: write data = {res_data[7:0], res_data[7:0]}, lane enables = 2'b01.
  - byte_op=0: write data = res_data, lane enables = 2'b11.
  - PSW/PC writes always use the full word; byte_op is ignored for them.
- Outputs are registered; no combinational path from inputs to strobes.
- res_valid while res_ready=0 is not accepted; the upstream must hold it.
- Reset mid-operation: mem_req drops immediately (asynchronously), the pending write is discarded and wb_done is not pulsed.

Optional Feature:
- Macro: WB_MEM_TIMEOUT_EN.
- Defined:
  - MEM_WAIT counts cycles with mem_ack low.
  - After MEM_TIMEOUT cycles, mem_req drops, wb_err pulses for 1 cycle, wb_done stays 0 and the FSM returns to IDLE.
  - An ack arriving in the same cycle the count expires wins: normal completion.
  - The counter clears on entry to MEM_WAIT.
- Not defined: no counter. MEM_WAIT waits indefinitely. wb_err is tied to 0 and the port still exists.

Decomposition:
- Package alu_wb_pkg:
  - dest_t enum: DEST_REG=2'd0, DEST_MEM=2'd1, DEST_PSW=2'd2, DEST_PC=2'd3.
  - wb_state_t enum.
  - Constants LANE_LO=2'b01 and LANE_BOTH=2'b11.
- Sub-module wb_timeout_counter: load, count, expired flag. Instantiated only under WB_MEM_TIMEOUT_EN.

Test Plan:
- Register write: rst_n low then high, res_valid=1, res_data=16'hA5C3, DEST_REG, dest_reg=5, byte_op=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=A5C3, rf_wbyte_en=11, wb_done=1; following cycle res_ready=1.
- Byte register write: res_data=16'h12F0, byte_op=1, dest_reg=2 -> rf_wdata=F0F0, rf_wbyte_en=01, single rf_we pulse.
- Memory, delayed ack: DEST_MEM, res_data=16'h0042, mem_ack after 3 cycles -> mem_req high 3 cycles with data stable, wb_done on the ack cycle, res_ready=0 throughout.
- Memory, ack in first MEM_WAIT cycle -> mem_req high 1 cycle, wb_done pulse; PSW write (16'h0007) next -> psw_we=1, wb_data=0007, no rf_we.
- Reset during MEM_WAIT: drop rst_n in cycle 2 -> mem_req=0 immediately, no wb_done, state IDLE, res_ready=1 after release.
- WB_MEM_TIMEOUT_EN, MEM_TIMEOUT=15, no ack -> mem_req high 15 cycles, wb_err pulse, wb_done=0, IDLE. Repeat with ack on cycle 15 -> wb_done, no wb_err.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// rtl/alu_wb_pkg.sv - destination tags, FSM states and lane-enable constants for ALU writeback
package alu_wb_pkg;

   typedef enum logic [1:0] {
      DEST_REG = 2'd0,
      DEST_MEM = 2'd1,
      DEST_PSW = 2'd2,
      DEST_PC  = 2'd3
   } dest_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } wb_state_t;

   localparam logic [1:0] LANE_LO   = 2'b01;
   localparam logic [1:0] LANE_BOTH = 2'b11;

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - memory-ack wait counter; expired is high during the LIMIT-th counted cycle
module wb_timeout_counter #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;

   // cnt_q holds (cycles already waited); saturates at the expiry value
   assign expired = (cnt_q == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_dest_writeback.sv
// rtl/alu_dest_writeback.sv - routes one ALU result to RF, memory, PSW or PC; WB_MEM_TIMEOUT_EN adds a mem_ack timeout
module alu_dest_writeback
   import alu_wb_pkg::*;
#(
   parameter int WORD_SIZE   = 16,
   parameter int REG_ADDR_W  = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [WORD_SIZE-1:0]  res_data,
   input  logic [1:0]            dest_sel,
   input  logic [REG_ADDR_W-1:0] dest_reg,
   input  logic                  byte_op,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [WORD_SIZE-1:0]  rf_wdata,
   output logic [1:0]            rf_wbyte_en,
   output logic                  psw_we,
   output logic                  pc_we,
   output logic [WORD_SIZE-1:0]  wb_data,
   output logic                  mem_req,
   output logic [WORD_SIZE-1:0]  mem_wdata,
   output logic [1:0]            mem_wbyte_en,
   input  logic                  mem_ack,
   output logic                  wb_done,
   output logic                  wb_err
);

   localparam int HALF = WORD_SIZE / 2;

   wb_state_t             state_q, state_d;
   dest_t                 dest;
   logic [WORD_SIZE-1:0]  lane_data, wdata_q;
   logic [1:0]            lane_en, ben_q;
   logic                  capture, rf_we_d, psw_we_d, pc_we_d, done_d, mem_req_d, wb_done_q;

   assign dest         = dest_t'(dest_sel);
   assign rf_wdata     = wdata_q;
   assign mem_wdata    = wdata_q;
   assign rf_wbyte_en  = ben_q;
   assign mem_wbyte_en = ben_q;

   // Memory completion is reported in the ack cycle itself so the control unit loses no cycle
   assign wb_done = wb_done_q | ((state_q == ST_MEM_WAIT) & mem_ack);

   always_comb begin
      lane_data = res_data;
      lane_en   = LANE_BOTH;
      if (byte_op) begin
         lane_data = {res_data[HALF-1:0], res_data[HALF-1:0]};
         lane_en   = LANE_LO;
      end
   end

`ifdef WB_MEM_TIMEOUT_EN
   logic timeout_hit, err_d;

   wb_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (capture && (dest == DEST_MEM)),
      .en      (state_q == ST_MEM_WAIT),
      .expired (timeout_hit)
   );
`endif

   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      rf_we_d   = 1'b0;
      psw_we_d  = 1'b0;
      pc_we_d   = 1'b0;
      done_d    = 1'b0;
      mem_req_d = mem_req;
`ifdef WB_MEM_TIMEOUT_EN
      err_d     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (res_valid) begin
               capture = 1'b1;
               if (dest == DEST_MEM) begin
                  state_d   = ST_MEM_WAIT;
                  mem_req_d = 1'b1;
               end else begin
                  state_d  = ST_WRITE;
                  done_d   = 1'b1;
                  rf_we_d  = (dest == DEST_REG);
                  psw_we_d = (dest == DEST_PSW);
                  pc_we_d  = (dest == DEST_PC);
               end
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
`ifdef WB_MEM_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
            end
`endif
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         res_ready <= 1'b1;
         rf_we     <= 1'b0;
         psw_we    <= 1'b0;
         pc_we     <= 1'b0;
         mem_req   <= 1'b0;
         wb_done_q <= 1'b0;
         rf_waddr  <= '0;
         wdata_q   <= '0;
         ben_q     <= '0;
         wb_data   <= '0;
      end else begin
         state_q   <= state_d;
         res_ready <= (state_d == ST_IDLE);
         rf_we     <= rf_we_d;
         psw_we    <= psw_we_d;
         pc_we     <= pc_we_d;
         mem_req   <= mem_req_d;
         wb_done_q <= done_d;
         if (capture) begin
            rf_waddr <= dest_reg;
            wdata_q  <= lane_data;
            ben_q    <= lane_en;
            wb_data  <= res_data;
         end
      end
   end

`ifdef WB_MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_err <= 1'b0;
      end else begin
         wb_err <= err_d;
      end
   end
`else
   assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dest_writeback.sv
// tb/tb_alu_dest_writeback.sv - self-checking bench for alu_dest_writeback with a transaction-level reference model
module tb_alu_dest_writeback;
   import alu_wb_pkg::*;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [15:0] res_data = '0;
   logic [1:0]  dest_sel = '0;
   logic [2:0]  dest_reg = '0;
   logic        byte_op = 1'b0;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [1:0]  rf_wbyte_en;
   logic        psw_we;
   logic        pc_we;
   logic [15:0] wb_data;
   logic        mem_req;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_wbyte_en;
   logic        mem_ack = 1'b0;
   logic        wb_done;
   logic        wb_err;

   int checks = 0;
   int errors = 0;

   alu_dest_writeback #(.WORD_SIZE(16), .REG_ADDR_W(3), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .dest_sel(dest_sel), .dest_reg(dest_reg), .byte_op(byte_op),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wbyte_en(rf_wbyte_en),
      .psw_we(psw_we), .pc_we(pc_we), .wb_data(wb_data), .mem_req(mem_req),
      .mem_wdata(mem_wdata), .mem_wbyte_en(mem_wbyte_en), .mem_ack(mem_ack),
      .wb_done(wb_done), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   // Reference: a byte op copies the low byte into both halves and enables only the low lane
   function automatic logic [15:0] model_data(input logic [15:0] d, input logic b);
      return b ? (d & 16'h00FF) * 16'h0101 : d;
   endfunction

   function automatic logic [1:0] model_en(input logic b);
      return b ? 2'd1 : 2'd3;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] ds, input logic [2:0] r, input logic b);
      res_data = d; dest_sel = ds; dest_reg = r; byte_op = b; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; res_valid = 1'b0; mem_ack = 1'b0;
      tick(); tick();
      checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got %b want 1", res_ready); end
      checks++; if ({rf_we, psw_we, pc_we, mem_req, wb_done, wb_err} !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b want 000000", {rf_we, psw_we, pc_we, mem_req, wb_done, wb_err}); end
      checks++; if ({rf_waddr, rf_wdata, rf_wbyte_en, wb_data, mem_wdata, mem_wbyte_en} !== '0) begin errors++; $display("FAIL reset_data_regs got %h/%h/%h/%h want 0", rf_waddr, rf_wdata, wb_data, mem_wbyte_en); end
      rst_n = 1'b1;
      tick();
      checks++; if (res_ready !== 1'b1 || wb_done !== 1'b0) begin errors++; $display("FAIL reset_release got ready=%b done=%b want 1/0", res_ready, wb_done); end
   endtask

   task automatic test_reg_write();
      send(16'hA5C3, DEST_REG, 3'd5, 1'b0);
      checks++; if ({rf_we, psw_we, pc_we} !== 3'b100) begin errors++; $display("FAIL reg_strobes got %b want 100", {rf_we, psw_we, pc_we}); end
      checks++; if (rf_waddr !== 3'd5) begin errors++; $display("FAIL reg_waddr got %0d want 5", rf_waddr); end
      checks++; if (rf_wdata !== 16'hA5C3 || rf_wbyte_en !== 2'b11) begin errors++; $display("FAIL reg_wdata got %h/%b want a5c3/11", rf_wdata, rf_wbyte_en); end
      checks++; if (wb_done !== 1'b1 || res_ready !== 1'b0) begin errors++; $display("FAIL reg_done got done=%b ready=%b want 1/0", wb_done, res_ready); end
      tick();
      checks++; if (res_ready !== 1'b1 || rf_we !== 1'b0 || wb_done !== 1'b0) begin errors++; $display("FAIL reg_after got ready=%b we=%b done=%b want 1/0/0", res_ready, rf_we, wb_done); end
   endtask

   task automatic test_byte_reg();
      send(16'h12F0, DEST_REG, 3'd2, 1'b1);
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd2) begin errors++; $display("FAIL byte_we got we=%b addr=%0d want 1/2", rf_we, rf_waddr); end
      checks++; if (rf_wdata !== 16'hF0F0 || rf_wbyte_en !== 2'b01) begin errors++; $display("FAIL byte_data got %h/%b want f0f0/01", rf_wdata, rf_wbyte_en); end
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL byte_single_pulse got %b want 0", rf_we); end
   endtask

   task automatic test_mem_delayed();
      send(16'h0042, DEST_MEM, 3'd0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) mem_ack = 1'b1;
         #1;
         checks++; if (mem_req !== 1'b1 || mem_wdata !== 16'h0042 || mem_wbyte_en !== 2'b11) begin errors++; $display("FAIL memdly_req c%0d got %b/%h/%b want 1/0042/11", k, mem_req, mem_wdata, mem_wbyte_en); end
         checks++; if (res_ready !== 1'b0 || wb_done !== (k == 3)) begin errors++; $display("FAIL memdly_done c%0d got ready=%b done=%b", k, res_ready, wb_done); end
         tick();
      end
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || res_ready !== 1'b1 || wb_done !== 1'b0) begin errors++; $display("FAIL memdly_end got req=%b ready=%b done=%b want 0/1/0", mem_req, res_ready, wb_done); end
   endtask

   task automatic test_mem_fast_then_psw();
      send(16'h3C3C, DEST_MEM, 3'd1, 1'b1);
      mem_ack = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b1 || wb_done !== 1'b1 || mem_wdata !== 16'h3C3C || mem_wbyte_en !== 2'b01) begin errors++; $display("FAIL memfast got req=%b done=%b data=%h en=%b", mem_req, wb_done, mem_wdata, mem_wbyte_en); end
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL memfast_end got req=%b ready=%b want 0/1", mem_req, res_ready); end
      send(16'h0007, DEST_PSW, 3'd4, 1'b1);
      checks++; if ({rf_we, psw_we, pc_we} !== 3'b010 || wb_data !== 16'h0007 || wb_done !== 1'b1) begin errors++; $display("FAIL psw got we=%b data=%h done=%b want 010/0007/1", {rf_we, psw_we, pc_we}, wb_data, wb_done); end
      tick();
   endtask

   task automatic test_ack_ignored();
      mem_ack = 1'b1;
      tick(); tick();
      checks++; if (mem_req !== 1'b0 || wb_done !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL idle_ack got req=%b done=%b ready=%b want 0/0/1", mem_req, wb_done, res_ready); end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_mem();
      send(16'h1234, DEST_MEM, 3'd0, 1'b0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || wb_done !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL rstmid got req=%b done=%b ready=%b want 0/0/1", mem_req, wb_done, res_ready); end
      mem_ack = 1'b1;
      tick();
      checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", wb_done); end
      mem_ack = 1'b0; rst_n = 1'b1;
      tick();
      checks++; if (res_ready !== 1'b1 || mem_req !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_release got ready=%b req=%b we=%b want 1/0/0", res_ready, mem_req, rf_we); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int ready_hi = 0;
      res_data = 16'hBEEF; dest_sel = DEST_PC; dest_reg = 3'd0; byte_op = 1'b1; res_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         pulses += int'(pc_we);
         ready_hi += int'(res_ready);
      end
      res_valid = 1'b0;
      checks++; if (pulses != 10 || ready_hi != 10) begin errors++; $display("FAIL b2b_rate got pc_we=%0d ready=%0d want 10/10", pulses, ready_hi); end
      checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL b2b_full_word got %h want beef", wb_data); end
      tick();
   endtask

   task automatic test_random();
      logic [15:0] d;
      logic [1:0]  ds;
      logic [2:0]  r;
      logic        b;
      int          dly;
      for (int n = 0; n < 60; n++) begin
         d = 16'($urandom); ds = 2'($urandom_range(0, 3)); r = 3'($urandom_range(0, 7));
         b = 1'($urandom_range(0, 1)); dly = $urandom_range(0, 4);
         repeat ($urandom_range(0, 2)) tick();
         send(d, ds, r, b);
         if (ds != DEST_MEM) begin
            checks++; if ({rf_we, psw_we, pc_we} !== {ds == DEST_REG, ds == DEST_PSW, ds == DEST_PC} || wb_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_strobe got %b done=%b dest=%0d", n, {rf_we, psw_we, pc_we}, wb_done, ds); end
            if (ds == DEST_REG) begin
               checks++; if (rf_waddr !== r || rf_wdata !== model_data(d, b) || rf_wbyte_en !== model_en(b)) begin errors++; $display("FAIL rnd%0d_rf got %0d/%h/%b want %0d/%h/%b", n, rf_waddr, rf_wdata, rf_wbyte_en, r, model_data(d, b), model_en(b)); end
            end else begin
               checks++; if (wb_data !== d) begin errors++; $display("FAIL rnd%0d_wbdata got %h want %h", n, wb_data, d); end
            end
            tick();
         end else begin
            for (int k = 0; k <= dly; k++) begin
               if (k == dly) mem_ack = 1'b1;
               #1;
               checks++; if (mem_req !== 1'b1 || mem_wdata !== model_data(d, b) || mem_wbyte_en !== model_en(b) || wb_done !== (k == dly)) begin errors++; $display("FAIL rnd%0d_mem c%0d got req=%b %h/%b done=%b want %h/%b", n, k, mem_req, mem_wdata, mem_wbyte_en, wb_done, model_data(d, b), model_en(b)); end
               tick();
            end
            mem_ack = 1'b0;
         end
         checks++; if (res_ready !== 1'b1 || mem_req !== 1'b0 || {rf_we, psw_we, pc_we, wb_done, wb_err} !== 5'b0) begin errors++; $display("FAIL rnd%0d_idle got ready=%b req=%b strobes=%b", n, res_ready, mem_req, {rf_we, psw_we, pc_we, wb_done, wb_err}); end
      end
   endtask

`ifdef WB_MEM_TIMEOUT_EN
   task automatic test_timeout();
      send(16'hCAFE, DEST_MEM, 3'd0, 1'b0);
      for (int k = 1; k <= TMO; k++) begin
         checks++; if (mem_req !== 1'b1 || wb_err !== 1'b0 || wb_done !== 1'b0) begin errors++; $display("FAIL tmo_wait c%0d got req=%b err=%b done=%b", k, mem_req, wb_err, wb_done); end
         tick();
      end
      checks++; if (mem_req !== 1'b0 || wb_err !== 1'b1 || wb_done !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL tmo_abort got req=%b err=%b done=%b ready=%b", mem_req, wb_err, wb_done, res_ready); end
      tick();
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse got %b want 0", wb_err); end
      send(16'hCAFE, DEST_MEM, 3'd0, 1'b0);
      for (int k = 1; k <= TMO; k++) begin
         if (k == TMO) begin
            mem_ack = 1'b1;
            #1;
            checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL tmo_ack_wins got done=%b want 1", wb_done); end
         end
         tick();
      end
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL tmo_ack_end got req=%b err=%b want 0/0", mem_req, wb_err); end
   endtask
`else
   task automatic test_no_timeout();
      send(16'hCAFE, DEST_MEM, 3'd0, 1'b0);
      for (int k = 1; k <= 3 * TMO; k++) begin
         checks++; if (mem_req !== 1'b1 || wb_err !== 1'b0 || wb_done !== 1'b0) begin errors++; $display("FAIL notmo_wait c%0d got req=%b err=%b done=%b", k, mem_req, wb_err, wb_done); end
         tick();
      end
      mem_ack = 1'b1;
      #1;
      checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL notmo_ack got done=%b want 1", wb_done); end
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL notmo_end got req=%b ready=%b want 0/1", mem_req, res_ready); end
   endtask
`endif

   initial begin
      test_reset();
      test_reg_write();
      test_byte_reg();
      test_mem_delayed();
      test_mem_fast_then_psw();
      test_ack_ignored();
      test_reset_mid_mem();
      test_back_to_back();
      test_random();
`ifdef WB_MEM_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
